// File: rtl/axi4_lite_write_master_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi4_lite_write_master_if                                                   |
// | AXI4-Lite write-channel bundle (AW, W, B) with master and slave views.      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface axi4_lite_write_master_if #(
  parameter int ADDRESS_WIDTH = 32
);
  logic [ADDRESS_WIDTH-1:0] write_addr;
  logic                     write_addr_valid;
  logic                     write_addr_ready;
  logic [31:0]              write_data;
  logic [3:0]               write_strb;
  logic                     write_data_valid;
  logic                     write_data_ready;
  logic [1:0]               write_resp;
  logic                     write_resp_valid;
  logic                     write_resp_ready;

  modport master (
    output write_addr, write_addr_valid,
    input  write_addr_ready,
    output write_data, write_strb, write_data_valid,
    input  write_data_ready,
    input  write_resp, write_resp_valid,
    output write_resp_ready
  );

  modport slave (
    input  write_addr, write_addr_valid,
    output write_addr_ready,
    input  write_data, write_strb, write_data_valid,
    output write_data_ready,
    output write_resp, write_resp_valid,
    input  write_resp_ready
  );
endinterface
`default_nettype wire

// File: rtl/axi4_lite_write_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi4_lite_write_master                                                      |
// | Single-outstanding AXI4-Lite write initiator with B-channel timeout.        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module axi4_lite_write_master #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  wire                       axi_clk,
  input  wire                       resetn,
  input  wire [ADDRESS_WIDTH-1:0]   cmd_addr,
  input  wire [31:0]                cmd_data,
  input  wire [3:0]                 cmd_strb,
  input  wire                       cmd_valid,
  output logic                      cmd_ready,
  axi4_lite_write_master_if.master  axi,
  output logic                      done,
  output logic [1:0]                resp_out,
  output logic                      timeout,
  output logic                      error
);

  localparam logic [1:0]  c_ST_IDLE      = 2'd0;
  localparam logic [1:0]  c_ST_SEND      = 2'd1;
  localparam logic [1:0]  c_ST_WAIT_RESP = 2'd2;
  localparam logic        c_TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  c_RESP_TIMEOUT = 2'b11;

  logic [1:0]               r_state;
  logic                     r_cmd_ready;
  logic                     r_aw_valid;
  logic                     r_w_valid;
  logic                     r_b_ready;
  logic                     r_aw_done;
  logic                     r_w_done;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [31:0]              r_data;
  logic [3:0]               r_strb;
  logic [15:0]              r_count;
  logic                     r_done;
  logic [1:0]               r_resp;
  logic                     r_timeout;

  logic [1:0]               w_state_nxt;
  logic                     w_cmd_ready_nxt;
  logic                     w_aw_valid_nxt;
  logic                     w_w_valid_nxt;
  logic                     w_b_ready_nxt;
  logic                     w_aw_done_nxt;
  logic                     w_w_done_nxt;
  logic [ADDRESS_WIDTH-1:0] w_addr_nxt;
  logic [31:0]              w_data_nxt;
  logic [3:0]               w_strb_nxt;
  logic [15:0]              w_count_nxt;
  logic                     w_done_nxt;
  logic [1:0]               w_resp_nxt;
  logic                     w_timeout_nxt;

  logic                     w_accept;
  logic                     w_aw_hs;
  logic                     w_w_hs;
  logic                     w_b_hs;
  logic                     w_aw_complete;
  logic                     w_w_complete;
  logic                     w_timeout_hit;

  assign w_accept      = (r_state == c_ST_IDLE) && cmd_valid && r_cmd_ready;
  assign w_aw_hs       = r_aw_valid && axi.write_addr_ready;
  assign w_w_hs        = r_w_valid && axi.write_data_ready;
  assign w_b_hs        = r_b_ready && axi.write_resp_valid;
  // Completion includes a handshake landing on this very edge, so AW and W may finish together.
  assign w_aw_complete = r_aw_done || w_aw_hs;
  assign w_w_complete  = r_w_done || w_w_hs;
  assign w_timeout_hit = c_TIMEOUT_EN && (r_count == c_TIMEOUT_LAST);

  always_ff @(posedge axi_clk) begin
    if (!resetn) begin
      r_state     <= c_ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_aw_valid  <= 1'b0;
      r_w_valid   <= 1'b0;
      r_b_ready   <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_strb      <= '0;
      r_count     <= '0;
      r_done      <= 1'b0;
      r_resp      <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_aw_valid  <= w_aw_valid_nxt;
      r_w_valid   <= w_w_valid_nxt;
      r_b_ready   <= w_b_ready_nxt;
      r_aw_done   <= w_aw_done_nxt;
      r_w_done    <= w_w_done_nxt;
      r_addr      <= w_addr_nxt;
      r_data      <= w_data_nxt;
      r_strb      <= w_strb_nxt;
      r_count     <= w_count_nxt;
      r_done      <= w_done_nxt;
      r_resp      <= w_resp_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_accept) w_state_nxt = c_ST_SEND;
      end
      c_ST_SEND: begin
        if (w_aw_complete && w_w_complete) w_state_nxt = c_ST_WAIT_RESP;
      end
      c_ST_WAIT_RESP: begin
        if (w_b_hs || w_timeout_hit) w_state_nxt = c_ST_IDLE;
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_cmd_ready_nxt = r_cmd_ready;
    w_aw_valid_nxt  = r_aw_valid;
    w_w_valid_nxt   = r_w_valid;
    w_b_ready_nxt   = r_b_ready;
    w_aw_done_nxt   = r_aw_done;
    w_w_done_nxt    = r_w_done;
    w_addr_nxt      = r_addr;
    w_data_nxt      = r_data;
    w_strb_nxt      = r_strb;
    w_count_nxt     = r_count;
    w_done_nxt      = 1'b0;
    w_resp_nxt      = r_resp;
    w_timeout_nxt   = r_timeout;
    case (r_state)
      c_ST_IDLE: begin
        w_cmd_ready_nxt = 1'b1;
        if (w_accept) begin
          w_cmd_ready_nxt = 1'b0;
          w_addr_nxt      = cmd_addr;
          w_data_nxt      = cmd_data;
          w_strb_nxt      = cmd_strb;
          w_aw_valid_nxt  = 1'b1;
          w_w_valid_nxt   = 1'b1;
          w_aw_done_nxt   = 1'b0;
          w_w_done_nxt    = 1'b0;
        end
      end
      c_ST_SEND: begin
        if (w_aw_hs) begin
          w_aw_valid_nxt = 1'b0;
          w_aw_done_nxt  = 1'b1;
        end
        if (w_w_hs) begin
          w_w_valid_nxt = 1'b0;
          w_w_done_nxt  = 1'b1;
        end
        if (w_aw_complete && w_w_complete) begin
          w_b_ready_nxt = 1'b1;
          w_count_nxt   = '0;
        end
      end
      c_ST_WAIT_RESP: begin
        if (w_b_hs) begin
          w_resp_nxt      = axi.write_resp;
          w_timeout_nxt   = 1'b0;
          w_done_nxt      = 1'b1;
          w_b_ready_nxt   = 1'b0;
          w_cmd_ready_nxt = 1'b1;
        end else begin
          w_count_nxt = r_count + 16'd1;
          if (w_timeout_hit) begin
            w_resp_nxt      = c_RESP_TIMEOUT;
            w_timeout_nxt   = 1'b1;
            w_done_nxt      = 1'b1;
            w_b_ready_nxt   = 1'b0;
            w_cmd_ready_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_cmd_ready_nxt = 1'b0;
        w_aw_valid_nxt  = 1'b0;
        w_w_valid_nxt   = 1'b0;
        w_b_ready_nxt   = 1'b0;
      end
    endcase
  end

  assign cmd_ready            = r_cmd_ready;
  assign axi.write_addr       = r_addr;
  assign axi.write_addr_valid = r_aw_valid;
  assign axi.write_data       = r_data;
  assign axi.write_strb       = r_strb;
  assign axi.write_data_valid = r_w_valid;
  assign axi.write_resp_ready = r_b_ready;
  assign done                 = r_done;
  assign resp_out             = r_resp;
  assign timeout              = r_timeout;
  assign error                = r_resp[1];

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_write_master.sv
`default_nettype none
// Directed self-checking bench for axi4_lite_write_master with a configurable-latency slave.
module tb_axi4_lite_write_master;
  logic        axi_clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic [3:0]  cmd_strb = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready, done, timeout, error;
  logic [1:0]  resp_out;

  axi4_lite_write_master_if #(.ADDRESS_WIDTH(32)) bus();

  axi4_lite_write_master #(.ADDRESS_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .axi_clk   (axi_clk),
    .resetn    (resetn),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .cmd_strb  (cmd_strb),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .axi       (bus),
    .done      (done),
    .resp_out  (resp_out),
    .timeout   (timeout),
    .error     (error)
  );

  always #5 axi_clk = ~axi_clk;

  int checks = 0;
  int errors = 0;
  int cfg_aw_wait = 0;
  int cfg_w_wait = 0;
  int cfg_b_wait = 0;
  logic [1:0] cfg_bresp = 2'b00;
  int aw_cnt = 0;
  int w_cnt = 0;
  int b_cnt = 0;
  bit aw_got = 0;
  bit w_got = 0;
  bit flush = 0;

  // Slave: handshakes observed at the rising edge, outputs updated at the falling edge.
  always @(posedge axi_clk) begin
    if (!resetn || flush) begin
      aw_got = 0;
      w_got = 0;
    end else begin
      if (bus.write_addr_valid && bus.write_addr_ready) aw_got = 1;
      if (bus.write_data_valid && bus.write_data_ready) w_got = 1;
      if (bus.write_resp_valid && bus.write_resp_ready) begin
        aw_got = 0;
        w_got = 0;
      end
    end
  end

  always @(negedge axi_clk) begin
    bus.write_resp = cfg_bresp;
    if (!resetn || flush) begin
      aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      bus.write_addr_ready = 1'b0;
      bus.write_data_ready = 1'b0;
      bus.write_resp_valid = 1'b0;
    end else begin
      if (bus.write_addr_valid) begin
        bus.write_addr_ready = (aw_cnt >= cfg_aw_wait);
        if (!bus.write_addr_ready) aw_cnt++;
      end else begin
        bus.write_addr_ready = 1'b0; aw_cnt = 0;
      end
      if (bus.write_data_valid) begin
        bus.write_data_ready = (w_cnt >= cfg_w_wait);
        if (!bus.write_data_ready) w_cnt++;
      end else begin
        bus.write_data_ready = 1'b0; w_cnt = 0;
      end
      if (aw_got && w_got) begin
        bus.write_resp_valid = (b_cnt >= cfg_b_wait);
        if (!bus.write_resp_valid) b_cnt++;
      end else begin
        bus.write_resp_valid = 1'b0; b_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && cmd_ready !== 1'b1; i++) tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wait_cmd_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wait_ready();
    cmd_addr = a; cmd_data = d; cmd_strb = s; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic slave_flush();
    flush = 1;
    @(negedge axi_clk);
    @(posedge axi_clk);
    #1;
    flush = 0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick(); tick();
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got %b exp 0", cmd_ready); end
    checks++; if (bus.write_addr_valid !== 1'b0) begin errors++; $display("FAIL rst_awvalid got %b exp 0", bus.write_addr_valid); end
    checks++; if (bus.write_data_valid !== 1'b0) begin errors++; $display("FAIL rst_wvalid got %b exp 0", bus.write_data_valid); end
    checks++; if (bus.write_resp_ready !== 1'b0) begin errors++; $display("FAIL rst_bready got %b exp 0", bus.write_resp_ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout got %b exp 0", timeout); end
    checks++; if (resp_out !== 2'b00) begin errors++; $display("FAIL rst_resp got %b exp 00", resp_out); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_error got %b exp 0", error); end
    checks++; if (bus.write_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", bus.write_addr); end
    checks++; if (bus.write_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h exp 0", bus.write_data); end
    checks++; if (bus.write_strb !== 4'h0) begin errors++; $display("FAIL rst_strb got %h exp 0", bus.write_strb); end
    resetn = 1'b1;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_cmd_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_basic();
    cfg_aw_wait = 0; cfg_w_wait = 0; cfg_b_wait = 0; cfg_bresp = 2'b00;
    issue(32'h10, 32'hDEADBEEF, 4'hF);
    checks++; if (bus.write_addr_valid !== 1'b1) begin errors++; $display("FAIL basic_awvalid got %b exp 1", bus.write_addr_valid); end
    checks++; if (bus.write_data_valid !== 1'b1) begin errors++; $display("FAIL basic_wvalid got %b exp 1", bus.write_data_valid); end
    checks++; if (bus.write_addr !== 32'h10) begin errors++; $display("FAIL basic_addr got %h exp 10", bus.write_addr); end
    checks++; if (bus.write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_data got %h exp deadbeef", bus.write_data); end
    checks++; if (bus.write_strb !== 4'hF) begin errors++; $display("FAIL basic_strb got %h exp f", bus.write_strb); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL basic_cmd_ready_busy got %b exp 0", cmd_ready); end
    tick();
    checks++; if (bus.write_addr_valid !== 1'b0 || bus.write_data_valid !== 1'b0) begin errors++; $display("FAIL basic_valids_drop got %b%b exp 00", bus.write_addr_valid, bus.write_data_valid); end
    checks++; if (bus.write_resp_ready !== 1'b1) begin errors++; $display("FAIL basic_bready got %b exp 1", bus.write_resp_ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_early got %b exp 0", done); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done got %b exp 1", done); end
    checks++; if (resp_out !== 2'b00 || error !== 1'b0) begin errors++; $display("FAIL basic_resp got %b/%b exp 00/0", resp_out, error); end
    checks++; if (bus.write_resp_ready !== 1'b0) begin errors++; $display("FAIL basic_bready_drop got %b exp 0", bus.write_resp_ready); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL basic_cmd_ready_back got %b exp 1", cmd_ready); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b exp 0", done); end
  endtask

  task automatic test_stall();
    cfg_aw_wait = 5; cfg_w_wait = 1; cfg_b_wait = 0; cfg_bresp = 2'b00;
    issue(32'h10, 32'h12345678, 4'h3);
    tick();
    checks++; if (bus.write_data_valid !== 1'b1 || bus.write_addr_valid !== 1'b1) begin errors++; $display("FAIL stall_e1_valids got %b%b exp 11", bus.write_addr_valid, bus.write_data_valid); end
    tick();
    checks++; if (bus.write_data_valid !== 1'b0) begin errors++; $display("FAIL stall_wvalid_drop got %b exp 0", bus.write_data_valid); end
    checks++; if (bus.write_resp_ready !== 1'b0) begin errors++; $display("FAIL stall_bready_early got %b exp 0", bus.write_resp_ready); end
    tick(); tick(); tick();
    checks++; if (bus.write_addr_valid !== 1'b1 || bus.write_addr !== 32'h10) begin errors++; $display("FAIL stall_aw_held got %b/%h exp 1/10", bus.write_addr_valid, bus.write_addr); end
    checks++; if (bus.write_resp_ready !== 1'b0) begin errors++; $display("FAIL stall_bready_wait got %b exp 0", bus.write_resp_ready); end
    tick();
    checks++; if (bus.write_addr_valid !== 1'b0 || bus.write_resp_ready !== 1'b1) begin errors++; $display("FAIL stall_aw_done got %b/%b exp 0/1", bus.write_addr_valid, bus.write_resp_ready); end
    tick();
    checks++; if (done !== 1'b1 || resp_out !== 2'b00) begin errors++; $display("FAIL stall_done got %b/%b exp 1/00", done, resp_out); end
    tick();
  endtask

  task automatic test_timeout();
    cfg_aw_wait = 0; cfg_w_wait = 0; cfg_b_wait = 9; cfg_bresp = 2'b00;
    issue(32'h20, 32'hCAFEF00D, 4'h1);
    tick();
    checks++; if (bus.write_resp_ready !== 1'b1) begin errors++; $display("FAIL tmo_bready got %b exp 1", bus.write_resp_ready); end
    for (int i = 0; i < 7; i++) tick();
    checks++; if (done !== 1'b0 || bus.write_resp_ready !== 1'b1) begin errors++; $display("FAIL tmo_early got %b/%b exp 0/1", done, bus.write_resp_ready); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL tmo_done got %b exp 1", done); end
    checks++; if (resp_out !== 2'b11 || timeout !== 1'b1 || error !== 1'b1) begin errors++; $display("FAIL tmo_status got %b/%b/%b exp 11/1/1", resp_out, timeout, error); end
    checks++; if (bus.write_resp_ready !== 1'b0) begin errors++; $display("FAIL tmo_bready_drop got %b exp 0", bus.write_resp_ready); end
    tick(); tick(); tick();
    checks++; if (done !== 1'b0 || bus.write_resp_ready !== 1'b0 || resp_out !== 2'b11) begin errors++; $display("FAIL tmo_late_bvalid got %b/%b/%b exp 0/0/11", done, bus.write_resp_ready, resp_out); end
    slave_flush();
  endtask

  task automatic test_hs_wins();
    cfg_aw_wait = 0; cfg_w_wait = 0; cfg_b_wait = 7; cfg_bresp = 2'b01;
    issue(32'h24, 32'h0BADF00D, 4'hC);
    for (int i = 0; i < 8; i++) tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL hswin_early got %b exp 0", done); end
    tick();
    checks++; if (done !== 1'b1 || resp_out !== 2'b01 || timeout !== 1'b0) begin errors++; $display("FAIL hswin_status got %b/%b/%b exp 1/01/0", done, resp_out, timeout); end
    tick();
  endtask

  task automatic test_slverr();
    cfg_aw_wait = 0; cfg_w_wait = 0; cfg_b_wait = 0; cfg_bresp = 2'b10;
    issue(32'h30, 32'h55AA55AA, 4'h5);
    tick(); tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL slverr_done got %b exp 1", done); end
    checks++; if (resp_out !== 2'b10 || error !== 1'b1 || timeout !== 1'b0) begin errors++; $display("FAIL slverr_status got %b/%b/%b exp 10/1/0", resp_out, error, timeout); end
    tick();
    checks++; if (resp_out !== 2'b10) begin errors++; $display("FAIL slverr_hold got %b exp 10", resp_out); end
    cfg_bresp = 2'b00;
  endtask

  task automatic test_mid_reset();
    cfg_aw_wait = 5; cfg_w_wait = 5; cfg_b_wait = 0; cfg_bresp = 2'b00;
    issue(32'h40, 32'h11223344, 4'hF);
    tick();
    resetn = 1'b0;
    tick();
    checks++; if (bus.write_addr_valid !== 1'b0 || bus.write_data_valid !== 1'b0 || bus.write_resp_ready !== 1'b0) begin errors++; $display("FAIL midrst_valids got %b%b%b exp 000", bus.write_addr_valid, bus.write_data_valid, bus.write_resp_ready); end
    checks++; if (cmd_ready !== 1'b0 || bus.write_addr !== 32'h0) begin errors++; $display("FAIL midrst_state got %b/%h exp 0/0", cmd_ready, bus.write_addr); end
    cfg_aw_wait = 0; cfg_w_wait = 0;
    resetn = 1'b1;
    tick();
    checks++; if (cmd_ready !== 1'b1 || bus.write_addr_valid !== 1'b0) begin errors++; $display("FAIL midrst_release got %b/%b exp 1/0", cmd_ready, bus.write_addr_valid); end
  endtask

  task automatic test_back_to_back();
    cfg_aw_wait = 0; cfg_w_wait = 0; cfg_b_wait = 0; cfg_bresp = 2'b00;
    wait_ready();
    cmd_addr = 32'h100; cmd_data = 32'hAAAA0001; cmd_strb = 4'hF; cmd_valid = 1'b1;
    tick();
    cmd_addr = 32'h200; cmd_data = 32'hBBBB0002; cmd_strb = 4'h6;
    tick();
    checks++; if (bus.write_addr_valid !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_no_overlap got %b/%b exp 0/0", bus.write_addr_valid, cmd_ready); end
    tick();
    checks++; if (done !== 1'b1 || cmd_ready !== 1'b1 || bus.write_addr_valid !== 1'b0) begin errors++; $display("FAIL b2b_first_done got %b/%b/%b exp 1/1/0", done, cmd_ready, bus.write_addr_valid); end
    tick();
    cmd_valid = 1'b0;
    checks++; if (bus.write_addr_valid !== 1'b1 || bus.write_addr !== 32'h200 || bus.write_data !== 32'hBBBB0002) begin errors++; $display("FAIL b2b_second_accept got %b/%h/%h exp 1/200/bbbb0002", bus.write_addr_valid, bus.write_addr, bus.write_data); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_gap got %b exp 0", done); end
    tick(); tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_second_done got %b exp 1", done); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_width got %b exp 0", done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_timeout();
    test_hs_wins();
    test_slverr();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
